prefetch_request_ctrl: RTL and testbench

- Initiator end of the icacheread / prefetched handshake: holds the current code fetch pointer and issues `icacheread_do/address/length` requests.
- Advances the pointer by each `prefetched_length` report from the icache.
- Sits between the decode-side redirect (`pr_reset` + new EIP) and the icache front end.
- Throttles on prefetch-FIFO fill, clamps every request to page boundary and CS limit, and signals a one-shot limit fault when the pointer runs past CS limit.

---
 rtl/prefetch_request_ctrl.sv | 118 +++++++++++
 tb/tb_prefetch_request_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_request_ctrl.sv
// Code fetch pointer and icache request generator: issues level requests clamped to
// page and CS limit, advances on delivery reports, and flags a one-shot limit fault.
module prefetch_request_ctrl #(
  parameter int unsigned FIFO_THRESHOLD = 8,
  parameter int unsigned MAX_LENGTH     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pr_reset,
  input  logic [31:0] new_eip,
  input  logic [31:0] cs_base,
  input  logic [31:0] cs_limit,
  input  logic [4:0]  prefetchfifo_used,
  output logic        icacheread_do,
  output logic [31:0] icacheread_address,
  output logic [4:0]  icacheread_length,
  input  logic        prefetched_do,
  input  logic [4:0]  prefetched_length,
  output logic        prefetch_limit_fault,
  output logic [31:0] fetch_eip
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [5:0] FIFO_THR = 6'(FIFO_THRESHOLD);
  localparam logic [4:0] MAX_LEN  = 5'(MAX_LENGTH);

  state_e      state_q, state_d;
  logic [31:0] eip_q, eip_d;
  logic [31:0] linear_s;
  logic [32:0] limit_rem_s;
  logic [12:0] page_rem_s;
  logic [4:0]  len_s;
  logic        fifo_ok_s;
  logic        req_s;
  logic        fault_s;

  // limit_rem is 33 bits so a full 4 GiB segment starting at 0 is representable
  assign linear_s    = cs_base + eip_q;
  assign limit_rem_s = (eip_q > cs_limit) ? 33'd0
                     : ({1'b0, cs_limit} - {1'b0, eip_q} + 33'd1);
  assign page_rem_s  = 13'd4096 - {1'b0, linear_s[11:0]};
  assign fifo_ok_s   = {1'b0, prefetchfifo_used} < FIFO_THR;

  // Request length: smallest of max burst, bytes left in page, bytes left in segment
  always_comb begin
    len_s = MAX_LEN;
    if (page_rem_s < 13'(len_s)) begin
      len_s = page_rem_s[4:0];
    end else begin
      len_s = len_s;
    end
    if (limit_rem_s < 33'(len_s)) begin
      len_s = limit_rem_s[4:0];
    end else begin
      len_s = len_s;
    end
  end

  // Next-state, pointer advance, request and fault pulse
  always_comb begin
    state_d = state_q;
    eip_d   = eip_q;
    req_s   = 1'b0;
    fault_s = 1'b0;
    if (pr_reset) begin
      state_d = ST_RUN;
      eip_d   = new_eip;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (limit_rem_s == 33'd0) begin
            fault_s = 1'b1;
            state_d = ST_FAULT;
          end else begin
            req_s = fifo_ok_s && (len_s != 5'd0);
            if (prefetched_do) begin
              eip_d = eip_q + {27'd0, prefetched_length};
            end else begin
              eip_d = eip_q;
            end
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and fetch pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      eip_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      eip_q   <= eip_d;
    end
  end

  assign icacheread_do        = req_s;
  assign icacheread_address   = linear_s;
  assign icacheread_length    = (state_q == ST_RUN) ? len_s : 5'd0;
  assign prefetch_limit_fault = fault_s;
  assign fetch_eip            = eip_q;

endmodule

// File: tb/tb_prefetch_request_ctrl.sv
// Self-checking bench for prefetch_request_ctrl: directed scenarios plus randomized
// stimulus compared every cycle against a behavioural model of the fetch pointer.
module tb_prefetch_request_ctrl;

  logic        clk;
  logic        rst_n;
  logic        pr_reset;
  logic [31:0] new_eip;
  logic [31:0] cs_base;
  logic [31:0] cs_limit;
  logic [4:0]  prefetchfifo_used;
  logic        icacheread_do;
  logic [31:0] icacheread_address;
  logic [4:0]  icacheread_length;
  logic        prefetched_do;
  logic [4:0]  prefetched_length;
  logic        prefetch_limit_fault;
  logic [31:0] fetch_eip;

  int errors = 0;
  int checks = 0;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FAULT = 2;

  int          m_state;
  logic [31:0] m_eip;

  prefetch_request_ctrl #(.FIFO_THRESHOLD(8), .MAX_LENGTH(16)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pr_reset            (pr_reset),
    .new_eip             (new_eip),
    .cs_base             (cs_base),
    .cs_limit            (cs_limit),
    .prefetchfifo_used   (prefetchfifo_used),
    .icacheread_do       (icacheread_do),
    .icacheread_address  (icacheread_address),
    .icacheread_length   (icacheread_length),
    .prefetched_do       (prefetched_do),
    .prefetched_length   (prefetched_length),
    .prefetch_limit_fault(prefetch_limit_fault),
    .fetch_eip           (fetch_eip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: bytes allowed = min(16, bytes to page end, bytes to segment end)
  function automatic logic [4:0] exp_len();
    longint lr;
    longint pg;
    longint m;
    longint lim;
    longint e;
    logic [31:0] lin;
    if (m_state != M_RUN) return 5'd0;
    lim = cs_limit;
    e   = m_eip;
    lin = cs_base + m_eip;
    lr  = (e > lim) ? 0 : lim - e + 1;
    pg  = 4096 - (lin & 32'hFFF);
    m   = 16;
    if (pg < m) m = pg;
    if (lr < m) m = lr;
    return 5'(m);
  endfunction

  function automatic logic exp_do();
    return (m_state == M_RUN) && !pr_reset && (prefetchfifo_used < 5'd8) && (exp_len() != 5'd0);
  endfunction

  function automatic logic exp_fault();
    return (m_state == M_RUN) && !pr_reset && (m_eip > cs_limit);
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic tick();
    @(posedge clk);
    if (pr_reset) begin
      m_state = M_RUN;
      m_eip   = new_eip;
    end else if (m_state == M_RUN) begin
      if (m_eip > cs_limit) m_state = M_FAULT;
      else if (prefetched_do) m_eip = m_eip + 32'(prefetched_length);
    end
    #1;
  endtask

  task automatic redirect(input logic [31:0] eip);
    pr_reset = 1'b1;
    new_eip  = eip;
    tick();
    pr_reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (icacheread_do !== 1'b0) begin errors++; $display("FAIL reset_do got=%0b want=0", icacheread_do); end
    checks++; if (prefetch_limit_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%0b want=0", prefetch_limit_fault); end
    checks++; if (fetch_eip !== 32'd0) begin errors++; $display("FAIL reset_eip got=%h want=0", fetch_eip); end
    checks++; if (icacheread_length !== 5'd0) begin errors++; $display("FAIL reset_len got=%0d want=0", icacheread_length); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    checks++; if (icacheread_do !== 1'b0) begin errors++; $display("FAIL idle_do got=%0b want=0", icacheread_do); end
  endtask

  task automatic test_run_advance();
    int lens[5] = '{4, 4, 4, 4, 3};
    logic [31:0] want;
    cs_base = 32'h0001_0000; cs_limit = 32'h0000_FFFF; prefetchfifo_used = 5'd0;
    pr_reset = 1'b1; new_eip = 32'h100; prefetched_do = 1'b0;
    #2;
    checks++; if (icacheread_do !== 1'b0) begin errors++; $display("FAIL prreset_cycle_do got=%0b want=0", icacheread_do); end
    tick();
    pr_reset = 1'b0;
    #2;
    checks++; if (icacheread_do !== 1'b1) begin errors++; $display("FAIL run_do got=%0b want=1", icacheread_do); end
    checks++; if (icacheread_address !== 32'h0001_0100) begin errors++; $display("FAIL run_addr got=%h want=00010100", icacheread_address); end
    checks++; if (icacheread_length !== 5'd16) begin errors++; $display("FAIL run_len got=%0d want=16", icacheread_length); end
    want = 32'h0001_0100;
    foreach (lens[i]) begin
      prefetched_do = 1'b1; prefetched_length = 5'(lens[i]);
      tick();
      want = want + 32'(lens[i]);
      prefetched_do = 1'b0;
      #2;
      checks++; if (icacheread_address !== want) begin errors++; $display("FAIL adv_addr[%0d] got=%h want=%h", i, icacheread_address, want); end
      checks++; if (icacheread_length !== 5'd16) begin errors++; $display("FAIL adv_len[%0d] got=%0d want=16", i, icacheread_length); end
    end
    checks++; if (fetch_eip !== 32'h113) begin errors++; $display("FAIL adv_eip got=%h want=113", fetch_eip); end
  endtask

  task automatic test_page_cross();
    cs_base = 32'd0; cs_limit = 32'hFFFF_FFFF;
    redirect(32'h0FF8);
    #2;
    checks++; if (icacheread_length !== 5'd8) begin errors++; $display("FAIL page_len got=%0d want=8", icacheread_length); end
    for (int i = 0; i < 2; i++) begin
      prefetched_do = 1'b1; prefetched_length = 5'd4;
      tick();
    end
    prefetched_do = 1'b0;
    #2;
    checks++; if (icacheread_address !== 32'h1000) begin errors++; $display("FAIL page_addr got=%h want=00001000", icacheread_address); end
    checks++; if (icacheread_length !== 5'd16) begin errors++; $display("FAIL page_len2 got=%0d want=16", icacheread_length); end
  endtask

  task automatic test_limit_fault();
    cs_base = 32'h0001_0000; cs_limit = 32'h105;
    redirect(32'h100);
    #2;
    checks++; if (icacheread_length !== 5'd6) begin errors++; $display("FAIL lim_len got=%0d want=6", icacheread_length); end
    prefetched_do = 1'b1; prefetched_length = 5'd4; tick();
    prefetched_length = 5'd2; tick();
    prefetched_do = 1'b0;
    #2;
    checks++; if (prefetch_limit_fault !== 1'b1) begin errors++; $display("FAIL lim_pulse got=%0b want=1", prefetch_limit_fault); end
    checks++; if (icacheread_do !== 1'b0) begin errors++; $display("FAIL lim_do got=%0b want=0", icacheread_do); end
    for (int i = 0; i < 3; i++) begin
      prefetched_do = 1'b1; prefetched_length = 5'd4;
      tick();
      #2;
      checks++; if (prefetch_limit_fault !== 1'b0) begin errors++; $display("FAIL lim_once[%0d] got=%0b want=0", i, prefetch_limit_fault); end
      checks++; if (icacheread_do !== 1'b0) begin errors++; $display("FAIL lim_hold_do[%0d] got=%0b want=0", i, icacheread_do); end
    end
    prefetched_do = 1'b0;
    checks++; if (fetch_eip !== 32'h106) begin errors++; $display("FAIL lim_eip got=%h want=106", fetch_eip); end
  endtask

  task automatic test_fifo_full();
    cs_limit = 32'hFFFF;
    redirect(32'h100);
    prefetchfifo_used = 5'd8; prefetched_do = 1'b1; prefetched_length = 5'd4;
    #2;
    checks++; if (icacheread_do !== 1'b0) begin errors++; $display("FAIL full_do got=%0b want=0", icacheread_do); end
    tick();
    prefetched_do = 1'b0;
    #2;
    checks++; if (fetch_eip !== 32'h104) begin errors++; $display("FAIL full_eip got=%h want=104", fetch_eip); end
    prefetchfifo_used = 5'd7;
    tick();
    #2;
    checks++; if (icacheread_do !== 1'b1) begin errors++; $display("FAIL unfull_do got=%0b want=1", icacheread_do); end
    checks++; if (icacheread_address !== 32'h0001_0104) begin errors++; $display("FAIL unfull_addr got=%h want=00010104", icacheread_address); end
    prefetchfifo_used = 5'd0;
  endtask

  task automatic test_back_to_back();
    redirect(32'h100);
    pr_reset = 1'b1; new_eip = 32'h2000; prefetched_do = 1'b1; prefetched_length = 5'd4;
    #2;
    checks++; if (icacheread_do !== 1'b0) begin errors++; $display("FAIL prio_do got=%0b want=0", icacheread_do); end
    tick();
    pr_reset = 1'b0; prefetched_do = 1'b0;
    #2;
    checks++; if (fetch_eip !== 32'h2000) begin errors++; $display("FAIL prio_eip got=%h want=2000", fetch_eip); end
    checks++; if (icacheread_do !== 1'b1) begin errors++; $display("FAIL prio_do2 got=%0b want=1", icacheread_do); end
  endtask

  task automatic test_wrap();
    cs_base = 32'd0; cs_limit = 32'hFFFF_FFFF;
    redirect(32'hFFFF_FFFE);
    prefetched_do = 1'b1; prefetched_length = 5'd4;
    tick();
    prefetched_do = 1'b0;
    #2;
    checks++; if (fetch_eip !== 32'd2) begin errors++; $display("FAIL wrap_eip got=%h want=2", fetch_eip); end
    checks++; if (prefetch_limit_fault !== 1'b0) begin errors++; $display("FAIL wrap_fault got=%0b want=0", prefetch_limit_fault); end
    checks++; if (icacheread_do !== 1'b1) begin errors++; $display("FAIL wrap_do got=%0b want=1", icacheread_do); end
  endtask

  task automatic test_async_reset();
    redirect(32'h300);
    #2;
    rst_n = 1'b0;
    #1;
    m_state = M_IDLE; m_eip = 32'd0;
    checks++; if (icacheread_do !== 1'b0) begin errors++; $display("FAIL arst_do got=%0b want=0", icacheread_do); end
    checks++; if (fetch_eip !== 32'd0) begin errors++; $display("FAIL arst_eip got=%h want=0", fetch_eip); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    #2;
    checks++; if (icacheread_do !== 1'b0) begin errors++; $display("FAIL arst_idle_do got=%0b want=0", icacheread_do); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      pr_reset = ($urandom_range(0, 14) == 0);
      if (pr_reset) begin
        case ($urandom_range(0, 2))
          0:       cs_limit = 32'hFFFF_FFFF;
          1:       cs_limit = 32'h2000 + $urandom_range(0, 64);
          default: cs_limit = $urandom;
        endcase
        cs_base = ($urandom_range(0, 1) == 0) ? 32'd0 : ($urandom & 32'hFFFF_FFF0) + $urandom_range(0, 15);
        case ($urandom_range(0, 2))
          0:       new_eip = cs_limit - $urandom_range(0, 24);
          1:       new_eip = 32'h0FF0 + $urandom_range(0, 31) - cs_base;
          default: new_eip = $urandom;
        endcase
      end
      prefetchfifo_used = 5'($urandom_range(0, 11));
      prefetched_do     = $urandom_range(0, 1);
      prefetched_length = 5'($urandom_range(0, 4));
      #2;
      checks++; if (icacheread_do !== exp_do()) begin errors++; $display("FAIL rnd_do[%0d] got=%0b want=%0b", n, icacheread_do, exp_do()); end
      checks++; if (icacheread_address !== cs_base + m_eip) begin errors++; $display("FAIL rnd_addr[%0d] got=%h want=%h", n, icacheread_address, cs_base + m_eip); end
      checks++; if (icacheread_length !== exp_len()) begin errors++; $display("FAIL rnd_len[%0d] got=%0d want=%0d", n, icacheread_length, exp_len()); end
      checks++; if (prefetch_limit_fault !== exp_fault()) begin errors++; $display("FAIL rnd_fault[%0d] got=%0b want=%0b", n, prefetch_limit_fault, exp_fault()); end
      checks++; if (fetch_eip !== m_eip) begin errors++; $display("FAIL rnd_eip[%0d] got=%h want=%h", n, fetch_eip, m_eip); end
      tick();
    end
    pr_reset = 1'b0; prefetched_do = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pr_reset = 1'b0; new_eip = 32'd0;
    cs_base = 32'h0001_0000; cs_limit = 32'hFFFF; prefetchfifo_used = 5'd0;
    prefetched_do = 1'b0; prefetched_length = 5'd0;
    m_state = M_IDLE; m_eip = 32'd0;
    test_reset();
    test_run_advance();
    test_page_cross();
    test_limit_fault();
    test_fifo_full();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
